mem_bus_rr_mux: RTL and testbench
=================================

// Module: mem_bus_rr_mux
// PURPOSE
//  N-to-1 multiplexer for the fixed-latency MEM request/response protocol. Arbitrates N requesters
//  onto one memory port, round-robin with grant lock. Routes each response back to its requester.
//  Adds a per-input response-valid strobe, which the plain MEM bus lacks.
//  Sits between core-side LSU/accelerator ports and a shared TCDM/SRAM bank.
// PARAMETERS
//  NumInp      4   number of requesters (>=1; 1 = pass-through plus p_valid)
//  AddrWidth   48  q_addr width
//  DataWidth   64  q_data/p_data width; StrbWidth = DataWidth/8
//  UserWidth   1   q_user width
//  RespLatency 1   memory cycles from q handshake to p_data valid (>=1)
// PORTS
//  clk_i          in   1                   clock, rising edge
//  rst_i          in   1                   synchronous reset, active-high
//  in_q_addr_i    in   NumInp*AddrWidth    per-input request address (input k at slice k)
//  in_q_write_i   in   NumInp              per-input write flag
//  in_q_amo_i     in   NumInp*4            per-input reqrsp_pkg::amo_op_e
//  in_q_data_i    in   NumInp*DataWidth    per-input write data
//  in_q_strb_i    in   NumInp*StrbWidth    per-input byte strobe
//  in_q_user_i    in   NumInp*UserWidth    per-input user payload
//  in_q_valid_i   in   NumInp              per-input request valid
//  in_q_ready_o   out  NumInp              per-input request ready
//  in_p_data_o    out  NumInp*DataWidth    per-input response data (all slices = out_p_data_i)
//  in_p_valid_o   out  NumInp              per-input response strobe
//  out_q_*_o      out  as above (1 lane)   addr/write/amo/data/strb/user/valid to memory
//  out_q_ready_i  in   1                   memory ready
//  out_p_data_i   in   DataWidth           memory response data
// BEHAVIOUR
//  - Request path is combinational (0 cycles):
//    - out_q_* = fields of granted input g.
//    - out_q_valid_o = |in_q_valid_i.
//    - in_q_ready_o[g] = out_q_ready_i; all other ready bits are 0.
//  - Round-robin arbitration:
//    - Pointer rr (IdxW = max(1,$clog2(NumInp))) gives the highest-priority index.
//    - g = first valid index at or after rr, modulo NumInp.
//    - After a handshake on input g, rr <= (g+1) mod NumInp. rr is unchanged otherwise.
//  - Grant lock:
//    - If out_q_valid_o && !out_q_ready_i, lock <= 1 and lock_idx <= g.
//    - While lock is set, g = lock_idx regardless of other valids. This keeps out_q_* stable,
//      as MEM protocol requires.
//    - Lock clears on the handshake.
//    - If a locked requester drops valid (protocol violation), lock clears that cycle and
//      arbitration resumes.
//  - Response routing:
//    - Shift register of RespLatency stages, each {vld, idx}.
//    - Stage 0 captures {handshake, g} every cycle.
//    - in_p_valid_o[k] = last.vld && last.idx==k, i.e. exactly RespLatency cycles after the
//      handshake.
//    - Every handshake (read, write or AMO) produces one response strobe.
//    - Back-to-back handshakes give back-to-back strobes, with no bubbles and no reordering.
//  - Reset (rst_i=1, sampled at posedge):
//    - rr=0, lock=0, all pipeline vld=0.
//    - While rst_i is high, out_q_valid_o=0, in_q_ready_o=0 and in_p_valid_o=0.
//    - Asserting reset mid-operation discards in-flight responses: no strobe is issued
//      after reset.
//  - Simultaneous events: a handshake in the same cycle as a response strobe to the same
//    input is legal and independent.
//  - NumInp=1: g=0 always; behaviour is pass-through plus in_p_valid_o.
// TESTING
//  - Reset: hold rst_i 3 cycles with all valids=1 -> out_q_valid_o=0, in_p_valid_o=0;
//    the first grant after release is input 0.
//  - Fairness: NumInp=4, all valid, ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3;
//    in_p_valid_o one-hot, following the same order 1 cycle later (RespLatency=1).
//  - Lock: inputs 1,3 valid, ready=0 for 5 cycles -> grant stays 1 and out_q_* stable;
//    raising input 0 does not preempt; after ready=1 the next grant is 3.
//  - Latency: RespLatency=3, single read from input 2 at cycle t ->
//    in_p_valid_o=4'b0100 at t+3 only, in_p_data_o slice 2 = out_p_data_i.
//  - Reset mid-flight: RespLatency=3, handshakes at t and t+1, rst_i at t+2 ->
//    no in_p_valid_o at t+3 or t+4.
//  - Random: constrained-random valid/ready with MEM_BUS_DV stability asserts on the output ->
//    per-input request count == response count; no assertion fires.

Source files
------------

// File: rtl/mem_bus_rr_mux.sv
// ============================================================================
// mem_bus_rr_mux
// ----------------------------------------------------------------------------
// N-to-1 multiplexer for the fixed-latency MEM request/response bus. Several
// requesters (LSU or accelerator ports) share one memory port, for example a
// TCDM/SRAM bank. Arbitration is round-robin. A grant lock holds the request
// payload stable while the memory stalls. Each response is routed back to its
// requester with a per-input valid strobe, which the plain MEM bus does not
// carry.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-high reset
//   in_q_*_i       per-input request fields, input k in slice k
//   in_q_valid_i   per-input request valid
//   in_q_ready_o   per-input request ready (only the granted input sees ready)
//   in_p_data_o    per-input response data (every slice carries out_p_data_i)
//   in_p_valid_o   per-input response strobe, RespLatency cycles after the
//                  handshake
//   out_q_*_o      request fields of the granted input, towards memory
//   out_q_valid_o  OR of all request valids (forced low during reset)
//   out_q_ready_i  memory ready
//   out_p_data_i   memory response data
// ============================================================================
module mem_bus_rr_mux #(
   parameter  int unsigned NumInp      = 4,
   parameter  int unsigned AddrWidth   = 48,
   parameter  int unsigned DataWidth   = 64,
   parameter  int unsigned UserWidth   = 1,
   parameter  int unsigned RespLatency = 1,
   localparam int unsigned StrbWidth   = DataWidth / 8,
   localparam int unsigned IdxW        = (NumInp > 1) ? $clog2(NumInp) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   // Requester side
   input  logic [NumInp*AddrWidth-1:0]    in_q_addr_i,
   input  logic [NumInp-1:0]              in_q_write_i,
   input  logic [NumInp*4-1:0]            in_q_amo_i,
   input  logic [NumInp*DataWidth-1:0]    in_q_data_i,
   input  logic [NumInp*StrbWidth-1:0]    in_q_strb_i,
   input  logic [NumInp*UserWidth-1:0]    in_q_user_i,
   input  logic [NumInp-1:0]              in_q_valid_i,
   output logic [NumInp-1:0]              in_q_ready_o,
   output logic [NumInp*DataWidth-1:0]    in_p_data_o,
   output logic [NumInp-1:0]              in_p_valid_o,
   // Memory side
   output logic [AddrWidth-1:0]           out_q_addr_o,
   output logic                           out_q_write_o,
   output logic [3:0]                     out_q_amo_o,
   output logic [DataWidth-1:0]           out_q_data_o,
   output logic [StrbWidth-1:0]           out_q_strb_o,
   output logic [UserWidth-1:0]           out_q_user_o,
   output logic                           out_q_valid_o,
   input  logic                           out_q_ready_i,
   input  logic [DataWidth-1:0]           out_p_data_i
);

   // Arbitration state: round-robin pointer and grant lock.
   logic [IdxW-1:0]   rr_q, rr_d;
   logic              lock_q, lock_d;
   logic [IdxW-1:0]   lockIdx_q, lockIdx_d;

   // Response pipeline: one {valid, index} pair per latency stage.
   logic [RespLatency-1:0]            pipeVld_q, pipeVld_d;
   logic [RespLatency-1:0][IdxW-1:0]  pipeIdx_q, pipeIdx_d;

   logic [IdxW-1:0]   grant;
   logic              outValid;
   logic              handshake;

   // The grant decision. A live lock wins outright, so the payload seen by
   // memory cannot change while it stalls. If the locked requester has
   // dropped its valid, the lock is ignored in this cycle and the normal
   // round-robin search picks the first valid input at or after the pointer.
   always_comb begin : arbitrate
      logic            found;
      logic [IdxW-1:0] candIdx;
      found   = 1'b0;
      candIdx = '0;
      grant   = '0;
      if (lock_q && in_q_valid_i[lockIdx_q]) begin
         grant = lockIdx_q;
         found = 1'b1;
      end
      for (int unsigned i = 0; i < NumInp; i++) begin
         candIdx = IdxW'((32'(rr_q) + i) % NumInp);
         if (!found && in_q_valid_i[candIdx]) begin
            grant = candIdx;
            found = 1'b1;
         end
      end
   end

   // Reset masks the request towards memory. Nothing can then be accepted
   // while the block is being cleared.
   assign outValid  = (|in_q_valid_i) && !rst_i;
   assign handshake = outValid && out_q_ready_i;

   // The request payload is a plain combinational mux on the grant index.
   assign out_q_addr_o  = in_q_addr_i[grant*AddrWidth +: AddrWidth];
   assign out_q_write_o = in_q_write_i[grant];
   assign out_q_amo_o   = in_q_amo_i[grant*4 +: 4];
   assign out_q_data_o  = in_q_data_i[grant*DataWidth +: DataWidth];
   assign out_q_strb_o  = in_q_strb_i[grant*StrbWidth +: StrbWidth];
   assign out_q_user_o  = in_q_user_i[grant*UserWidth +: UserWidth];
   assign out_q_valid_o = outValid;

   // Only the granted requester sees memory ready. All other inputs see a
   // stall, so they keep their requests pending.
   always_comb begin
      in_q_ready_o = '0;
      if (outValid) begin
         in_q_ready_o[grant] = out_q_ready_i;
      end
   end

   // Next arbitration state. The pointer moves one past the winner only on
   // an accepted request. The lock is taken whenever a request is presented
   // but not accepted. Otherwise it is released: on the handshake, on an
   // idle bus, or when the locked requester withdrew. In the withdrawn case
   // the lock may be taken again at once, for whichever input now stalls.
   always_comb begin
      rr_d      = rr_q;
      lock_d    = 1'b0;
      lockIdx_d = lockIdx_q;
      if (handshake) begin
         rr_d = IdxW'((32'(grant) + 32'd1) % NumInp);
      end
      if (outValid && !out_q_ready_i) begin
         lock_d    = 1'b1;
         lockIdx_d = grant;
      end
   end

   // Response pipeline shift. Stage 0 records every cycle whether a request
   // was accepted and from whom. That record comes out of the last stage
   // exactly RespLatency cycles later, in step with the memory data.
   always_comb begin
      pipeVld_d    = pipeVld_q;
      pipeIdx_d    = pipeIdx_q;
      pipeVld_d[0] = handshake;
      pipeIdx_d[0] = grant;
      for (int unsigned i = 1; i < RespLatency; i++) begin
         pipeVld_d[i] = pipeVld_q[i-1];
         pipeIdx_d[i] = pipeIdx_q[i-1];
      end
   end

   // Control state registers. Clearing the pipeline valids discards every
   // response still in flight, so no strobe appears after a reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q      <= '0;
         lock_q    <= 1'b0;
         lockIdx_q <= '0;
         pipeVld_q <= '0;
      end else begin
         rr_q      <= rr_d;
         lock_q    <= lock_d;
         lockIdx_q <= lockIdx_d;
         pipeVld_q <= pipeVld_d;
      end
   end

   // The index payload is only meaningful next to its valid bit, so it
   // needs no reset.
   always_ff @(posedge clk_i) begin
      pipeIdx_q <= pipeIdx_d;
   end

   // Response routing. The data fans out to every requester. The strobe
   // marks the one that owns it, and is forced low while reset is held.
   always_comb begin
      in_p_valid_o = '0;
      if (!rst_i && pipeVld_q[RespLatency-1]) begin
         in_p_valid_o[pipeIdx_q[RespLatency-1]] = 1'b1;
      end
   end

   assign in_p_data_o = {NumInp{out_p_data_i}};

endmodule

// File: tb/tb_mem_bus_rr_mux.sv
// ============================================================================
// tb_mem_bus_rr_mux
// ----------------------------------------------------------------------------
// Two instances share one set of stimulus: dutA with RespLatency=1 and dutB
// with RespLatency=3. A reference model of the round-robin pointer and the
// grant lock predicts the grant in every cycle. Each accepted request pushes
// an expected response, with its due cycle, into a queue for each instance.
// tick() pops those entries and compares them against the strobes the DUTs
// produce.
// ============================================================================
module tb_mem_bus_rr_mux;

   localparam int N  = 4;
   localparam int AW = 48;
   localparam int DW = 64;
   localparam int SW = DW / 8;
   localparam int UW = 1;

   typedef struct {
      int idx;
      int due;
   } rsp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [N*AW-1:0]   qAddr;
   logic [N-1:0]      qWrite;
   logic [N*4-1:0]    qAmo;
   logic [N*DW-1:0]   qData;
   logic [N*SW-1:0]   qStrb;
   logic [N*UW-1:0]   qUser;
   logic [N-1:0]      qValid;
   logic              outReady;
   logic [DW-1:0]     outPData;

   logic [N-1:0]      readyA, readyB, pValidA, pValidB;
   logic [N*DW-1:0]   pDataA, pDataB;
   logic [AW-1:0]     oAddrA, oAddrB;
   logic              oWriteA, oWriteB, oValidA, oValidB;
   logic [3:0]        oAmoA, oAmoB;
   logic [DW-1:0]     oDataA, oDataB;
   logic [SW-1:0]     oStrbA, oStrbB;
   logic [UW-1:0]     oUserA, oUserB;

   rsp_t sbA[$];
   rsp_t sbB[$];
   int   reqCnt[N];
   int   rspCntA[N];
   int   rspCntB[N];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model state
   int   mRr = 0;
   bit   mLock = 1'b0;
   int   mLockIdx = 0;
   int   mLastHs = -1;

   always #5 clk = ~clk;

   // Counts the cycle that starts at each rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   mem_bus_rr_mux #(.NumInp(N), .AddrWidth(AW), .DataWidth(DW), .UserWidth(UW), .RespLatency(1)) dutA (
      .clk_i(clk), .rst_i(rst),
      .in_q_addr_i(qAddr), .in_q_write_i(qWrite), .in_q_amo_i(qAmo), .in_q_data_i(qData),
      .in_q_strb_i(qStrb), .in_q_user_i(qUser), .in_q_valid_i(qValid), .in_q_ready_o(readyA),
      .in_p_data_o(pDataA), .in_p_valid_o(pValidA),
      .out_q_addr_o(oAddrA), .out_q_write_o(oWriteA), .out_q_amo_o(oAmoA), .out_q_data_o(oDataA),
      .out_q_strb_o(oStrbA), .out_q_user_o(oUserA), .out_q_valid_o(oValidA),
      .out_q_ready_i(outReady), .out_p_data_i(outPData)
   );

   mem_bus_rr_mux #(.NumInp(N), .AddrWidth(AW), .DataWidth(DW), .UserWidth(UW), .RespLatency(3)) dutB (
      .clk_i(clk), .rst_i(rst),
      .in_q_addr_i(qAddr), .in_q_write_i(qWrite), .in_q_amo_i(qAmo), .in_q_data_i(qData),
      .in_q_strb_i(qStrb), .in_q_user_i(qUser), .in_q_valid_i(qValid), .in_q_ready_o(readyB),
      .in_p_data_o(pDataB), .in_p_valid_o(pValidB),
      .out_q_addr_o(oAddrB), .out_q_write_o(oWriteB), .out_q_amo_o(oAmoB), .out_q_data_o(oDataB),
      .out_q_strb_o(oStrbB), .out_q_user_o(oUserB), .out_q_valid_o(oValidB),
      .out_q_ready_i(outReady), .out_p_data_i(outPData)
   );

   // Expected grant: -1 while reset is held or nothing is valid. Otherwise a
   // live lock wins, or else the first valid input at or after the pointer.
   function automatic int modelGrant();
      if (rst || qValid == '0) return -1;
      if (mLock && qValid[mLockIdx]) return mLockIdx;
      for (int i = 0; i < N; i++) begin
         if (qValid[(mRr + i) % N]) return (mRr + i) % N;
      end
      return -1;
   endfunction

   // Ends the current cycle. The response strobes of this cycle are checked
   // against the scoreboard on the falling edge. The model then advances,
   // and the task returns just after the next rising edge.
   task automatic tick();
      int g;
      logic [N-1:0] expA, expB;
      @(negedge clk);
      if (rst) begin
         sbA.delete();
         sbB.delete();
      end
      expA = '0;
      expB = '0;
      if (sbA.size() > 0 && sbA[0].due == cyc) expA[sbA[0].idx] = 1'b1;
      if (sbB.size() > 0 && sbB[0].due == cyc) expB[sbB[0].idx] = 1'b1;
      checks++;
      if (pValidA !== expA) begin
         errors++;
         $display("[TB] FAIL rsp_strobe_A cyc=%0d got %b expected %b", cyc, pValidA, expA);
      end
      checks++;
      if (pValidB !== expB) begin
         errors++;
         $display("[TB] FAIL rsp_strobe_B cyc=%0d got %b expected %b", cyc, pValidB, expB);
      end
      if (expA != '0) begin
         checks++;
         if (pDataA[sbA[0].idx*DW +: DW] !== outPData) begin
            errors++;
            $display("[TB] FAIL rsp_data_A got %h expected %h", pDataA[sbA[0].idx*DW +: DW], outPData);
         end
         rspCntA[sbA[0].idx]++;
         void'(sbA.pop_front());
      end
      if (expB != '0) begin
         checks++;
         if (pDataB[sbB[0].idx*DW +: DW] !== outPData) begin
            errors++;
            $display("[TB] FAIL rsp_data_B got %h expected %h", pDataB[sbB[0].idx*DW +: DW], outPData);
         end
         rspCntB[sbB[0].idx]++;
         void'(sbB.pop_front());
      end
      g = modelGrant();
      mLastHs = -1;
      if (rst) begin
         mRr   = 0;
         mLock = 1'b0;
      end else if (g >= 0 && outReady) begin
         sbA.push_back(rsp_t'{idx: g, due: cyc + 1});
         sbB.push_back(rsp_t'{idx: g, due: cyc + 3});
         reqCnt[g]++;
         mRr     = (g + 1) % N;
         mLock   = 1'b0;
         mLastHs = g;
      end else if (g >= 0) begin
         mLock    = 1'b1;
         mLockIdx = g;
      end else begin
         mLock = 1'b0;
      end
      @(posedge clk);
      #1;
      outPData = {$urandom, $urandom};
   endtask

   task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic rdy);
      rst      = r;
      qValid   = v;
      outReady = rdy;
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 4'hF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (oValidA !== 1'b0 || oValidB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %b/%b expected 0", oValidA, oValidB);
         end
         checks++;
         if (readyA !== '0 || readyB !== '0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b/%b expected 0000", readyA, readyB);
         end
         tick();
      end
      applyStimulus(1'b0, 4'hF, 1'b1);
      checks++;
      if (readyA !== 4'b0001 || readyB !== 4'b0001 || oAddrA !== qAddr[0 +: AW]) begin
         errors++;
         $display("[TB] FAIL reset_first_grant got %b addr %h expected 0001 addr %h", readyA, oAddrA, qAddr[0 +: AW]);
      end
      tick();
      applyStimulus(1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_fairness();
      logic [N-1:0] expR;
      applyStimulus(1'b1, 4'h0, 1'b1);
      tick();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 4'hF, 1'b1);
         expR = '0;
         expR[i % N] = 1'b1;
         checks++;
         if (readyA !== expR || readyB !== expR) begin
            errors++;
            $display("[TB] FAIL fair_grant step=%0d got %b/%b expected %b", i, readyA, readyB, expR);
         end
         checks++;
         if (oAddrA !== qAddr[(i % N)*AW +: AW]) begin
            errors++;
            $display("[TB] FAIL fair_addr step=%0d got %h expected %h", i, oAddrA, qAddr[(i % N)*AW +: AW]);
         end
         tick();
      end
      applyStimulus(1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_lock();
      logic [N-1:0] v;
      applyStimulus(1'b1, 4'h0, 1'b0);
      tick();
      v = 4'b1010;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) v[0] = 1'b1;
         applyStimulus(1'b0, v, 1'b0);
         checks++;
         if (oValidA !== 1'b1 || readyA !== '0) begin
            errors++;
            $display("[TB] FAIL lock_stall step=%0d got valid %b ready %b expected 1 0000", i, oValidA, readyA);
         end
         checks++;
         if (oAddrA !== qAddr[1*AW +: AW] || oAddrB !== qAddr[1*AW +: AW] || oDataA !== qData[1*DW +: DW]) begin
            errors++;
            $display("[TB] FAIL lock_hold step=%0d got %h expected %h", i, oAddrA, qAddr[1*AW +: AW]);
         end
         tick();
      end
      applyStimulus(1'b0, v, 1'b1);
      checks++;
      if (readyA !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL lock_release got %b expected 0010", readyA);
      end
      tick();
      applyStimulus(1'b0, v, 1'b1);
      checks++;
      if (readyA !== 4'b1000 || oAddrA !== qAddr[3*AW +: AW]) begin
         errors++;
         $display("[TB] FAIL lock_next_grant got %b expected 1000", readyA);
      end
      tick();
      applyStimulus(1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_latency();
      logic [N-1:0] expV;
      applyStimulus(1'b1, 4'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 4'h0, 1'b1);
      tick();
      qWrite = '0;
      applyStimulus(1'b0, 4'b0100, 1'b1);
      checks++;
      if (readyB !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL lat_grant got %b expected 0100", readyB);
      end
      tick();
      for (int j = 1; j <= 4; j++) begin
         applyStimulus(1'b0, 4'h0, 1'b1);
         expV = (j == 3) ? 4'b0100 : 4'b0000;
         checks++;
         if (pValidB !== expV) begin
            errors++;
            $display("[TB] FAIL lat3_strobe t+%0d got %b expected %b", j, pValidB, expV);
         end
         if (j == 3) begin
            checks++;
            if (pDataB[2*DW +: DW] !== outPData) begin
               errors++;
               $display("[TB] FAIL lat3_data got %h expected %h", pDataB[2*DW +: DW], outPData);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_midflight();
      applyStimulus(1'b1, 4'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 4'b0001, 1'b1);
      tick();
      applyStimulus(1'b0, 4'b0010, 1'b1);
      tick();
      applyStimulus(1'b1, 4'h0, 1'b1);
      tick();
      for (int j = 3; j <= 4; j++) begin
         applyStimulus(1'b0, 4'h0, 1'b1);
         checks++;
         if (pValidB !== '0 || pValidA !== '0) begin
            errors++;
            $display("[TB] FAIL midflight_discard t+%0d got %b/%b expected 0000", j, pValidA, pValidB);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [N-1:0] v;
      logic [N-1:0] expR;
      logic         prevStall;
      logic [AW-1:0] prevAddr;
      int           g;
      applyStimulus(1'b1, 4'h0, 1'b1);
      tick();
      for (int k = 0; k < N; k++) begin
         reqCnt[k]  = 0;
         rspCntA[k] = 0;
         rspCntB[k] = 0;
      end
      v = '0;
      prevStall = 1'b0;
      prevAddr  = '0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!(v[k] && k != mLastHs)) begin
               v[k] = 1'($urandom_range(0, 1));
               qAddr[k*AW +: AW] = AW'({$urandom, $urandom});
               qData[k*DW +: DW] = {$urandom, $urandom};
               qWrite[k]         = 1'($urandom_range(0, 1));
               qAmo[k*4 +: 4]    = 4'($urandom_range(0, 15));
               qStrb[k*SW +: SW] = 8'($urandom_range(0, 255));
            end
         end
         applyStimulus(1'b0, v, ($urandom_range(0, 3) != 0));
         g = modelGrant();
         checks++;
         if (oValidA !== (g >= 0) || oValidB !== (g >= 0)) begin
            errors++;
            $display("[TB] FAIL rand_valid c=%0d got %b expected %b", c, oValidA, (g >= 0));
         end
         if (g >= 0) begin
            expR = '0;
            expR[g] = outReady;
            checks++;
            if (readyA !== expR || readyB !== expR) begin
               errors++;
               $display("[TB] FAIL rand_ready c=%0d got %b expected %b", c, readyA, expR);
            end
            checks++;
            if (oAddrA !== qAddr[g*AW +: AW] || oDataA !== qData[g*DW +: DW] ||
                oWriteA !== qWrite[g] || oAmoA !== qAmo[g*4 +: 4] || oStrbB !== qStrb[g*SW +: SW]) begin
               errors++;
               $display("[TB] FAIL rand_payload c=%0d got %h expected %h", c, oAddrA, qAddr[g*AW +: AW]);
            end
         end
         if (prevStall) begin
            checks++;
            if (oAddrA !== prevAddr) begin
               errors++;
               $display("[TB] FAIL rand_stable c=%0d got %h expected %h", c, oAddrA, prevAddr);
            end
         end
         prevStall = (g >= 0) && !outReady;
         prevAddr  = oAddrA;
         tick();
      end
      applyStimulus(1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (rspCntA[k] !== reqCnt[k] || rspCntB[k] !== reqCnt[k]) begin
            errors++;
            $display("[TB] FAIL rand_count in%0d got %0d/%0d expected %0d", k, rspCntA[k], rspCntB[k], reqCnt[k]);
         end
      end
   endtask

   // Fixed payload for the directed tests: each input gets its own
   // recognisable address and data, so a wrong grant is visible.
   initial begin
      rst      = 1'b1;
      qValid   = '0;
      outReady = 1'b0;
      outPData = 64'h0123_4567_89AB_CDEF;
      qWrite   = 4'b0101;
      qUser    = 4'b1001;
      for (int k = 0; k < N; k++) begin
         qAddr[k*AW +: AW] = AW'(48'hA000_0000_0000 + 48'(k) * 48'h100);
         qData[k*DW +: DW] = DW'(64'hD000_0000_0000_0000 + 64'(k));
         qAmo[k*4 +: 4]    = 4'(k + 1);
         qStrb[k*SW +: SW] = 8'(8'hF0 | 8'(k));
      end
      test_reset();
      test_fairness();
      test_lock();
      test_latency();
      test_reset_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
